// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, funct3 codes,
// FSM states, ALU operations and the ALU datapath function.
package cpu_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // SUB only exists for register-register ops; instr[30] on OP-IMM is an immediate bit
    function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            F3_ADD:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu_f(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 integer register file: two async read ports, one sync write port,
// x0 reads as zero and ignores writes.
module cpu_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0][31:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && wr_addr != 5'd0) regs_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs_q[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs_q[rs2_addr];

endmodule

// File: rtl/rv32_multicycle_cpu.sv
// Multi-cycle RV32I subset core, Harvard ports, FETCH/EXEC(/MEM) sequencing.
// Define CPU_HALT_EN to add the `halted` port and stop on ECALL/EBREAK/unknown opcodes.
module rv32_multicycle_cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        dmem_write,
    output logic        dmem_read,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
`ifdef CPU_HALT_EN
    ,
    output logic        halted
`endif
);

`ifdef CPU_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  ld_rd_q, ld_rd_d;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4, alu_b, alu_y;
    alu_op_e     alu_op;
    logic        br_taken, halt_req;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign opcode = imem_data[6:0];
    assign rd     = imem_data[11:7];
    assign f3     = imem_data[14:12];
    assign rs1    = imem_data[19:15];
    assign rs2    = imem_data[24:20];

    assign imm_i = {{20{imem_data[31]}}, imem_data[31:20]};
    assign imm_s = {{20{imem_data[31]}}, imem_data[31:25], imem_data[11:7]};
    assign imm_b = {{19{imem_data[31]}}, imem_data[31], imem_data[7], imem_data[30:25], imem_data[11:8], 1'b0};
    assign imm_u = {imem_data[31:12], 12'd0};
    assign imm_j = {{11{imem_data[31]}}, imem_data[31], imem_data[19:12], imem_data[20], imem_data[30:21], 1'b0};

    cpu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .we       (rf_we),
        .wr_addr  (rf_wa),
        .wr_data  (rf_wd)
    );

    assign pc_plus4  = pc_q + 32'd4;
    assign alu_op    = alu_dec(f3, imem_data[30], opcode == OPC_OP);
    assign alu_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign alu_y     = alu_f(alu_op, rs1_val, alu_b);
    assign imem_addr = pc_q;

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            F3_BEQ:  br_taken = rs1_val == rs2_val;
            F3_BNE:  br_taken = rs1_val != rs2_val;
            F3_BLT:  br_taken = $signed(rs1_val) <  $signed(rs2_val);
            F3_BGE:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            F3_BLTU: br_taken = rs1_val <  rs2_val;
            F3_BGEU: br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ld_rd_d    = ld_rd_q;
        rf_we      = 1'b0;
        rf_wa      = rd;
        rf_wd      = '0;
        dmem_write = 1'b0;
        dmem_read  = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        halt_req   = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_plus4;
                case (opcode)
                    OPC_LUI:    begin rf_we = 1'b1; rf_wd = imm_u; end
                    OPC_AUIPC:  begin rf_we = 1'b1; rf_wd = pc_q + imm_u; end
                    OPC_JAL: begin
                        rf_we = 1'b1;
                        rf_wd = pc_plus4;
                        pc_d  = pc_q + imm_j;
                    end
                    OPC_JALR: begin
                        rf_we = 1'b1;
                        rf_wd = pc_plus4;
                        pc_d  = (rs1_val + imm_i) & ~32'd1;
                    end
                    OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
                    OPC_LOAD: begin
                        // pc advances when the load data is written back in MEM
                        dmem_read = 1'b1;
                        dmem_addr = rs1_val + imm_i;
                        pc_d      = pc_q;
                        ld_rd_d   = rd;
                        state_d   = S_MEM;
                    end
                    OPC_STORE: begin
                        dmem_write = 1'b1;
                        dmem_addr  = rs1_val + imm_s;
                        dmem_wdata = rs2_val;
                    end
                    OPC_OP_IMM, OPC_OP: begin rf_we = 1'b1; rf_wd = alu_y; end
                    OPC_MISC_MEM: ;
                    OPC_SYSTEM: if (f3 == 3'b000 && imem_data[31:21] == '0) halt_req = 1'b1;
                    default:    halt_req = 1'b1;
                endcase
                if (HALT_EN && halt_req) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end
            end
            S_MEM: begin
                rf_we   = 1'b1;
                rf_wa   = ld_rd_q;
                rf_wd   = dmem_rdata;
                pc_d    = pc_plus4;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ld_rd_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ld_rd_q <= ld_rd_d;
        end
    end

`ifdef CPU_HALT_EN
    assign halted = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_rv32_multicycle_cpu.sv
// Program-driven bench: each test loads a small program, queues the stores it
// must produce, and checks them as the core emits dmem write pulses.
module tb_rv32_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_write, dmem_read;
`ifdef CPU_HALT_EN
    logic        halted;
`endif

    rv32_multicycle_cpu #(.RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_write (dmem_write),
        .dmem_read  (dmem_read),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata)
`ifdef CPU_HALT_EN
        ,
        .halted     (halted)
`endif
    );

    always #2 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
    st_t         exp_q[$];
    logic [31:0] fetch_q[$];
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    logic [31:0] trace_prev;
    int          pc_cyc [0:63];
    int          checks = 0;
    int          fails  = 0;
    int          p_idx;

    always @(posedge clk) begin
        imem_data <= imem[imem_addr[9:2]];
        if (dmem_write) dmem[dmem_addr[9:2]] <= dmem_wdata;
        if (dmem_read)  dmem_rdata <= dmem[dmem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // store scoreboard, fetch trace and per-pc cycle counts
    always @(negedge clk) begin
        if (!rst_n) begin
            trace_prev = '1;
            fetch_q.delete();
            for (int i = 0; i < 64; i++) pc_cyc[i] = 0;
        end else begin
            pc_cyc[imem_addr[7:2]]++;
            if (imem_addr !== trace_prev) begin
                fetch_q.push_back(imem_addr);
                trace_prev = imem_addr;
            end
            if (dmem_write) begin
                chk("st_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    st_t e;
                    e = exp_q.pop_front();
                    chk("st_addr", dmem_addr, e.addr);
                    chk("st_data", dmem_wdata, e.data);
                end
            end
        end
    end

    function automatic logic [31:0] i_op(input logic [2:0] f3, input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3, input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        logic [11:0] v;
        v = 12'(imm);
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input int rs1, input int rs2, input int off);
        logic [12:0] v;
        v = 13'(off);
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input int rd, input int off);
        logic [20:0] v;
        v = 21'(off);
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b1100111};
    endfunction
    function automatic logic [31:0] u_op(input logic [6:0] opc, input int rd, input int imm20);
        return {20'(imm20), 5'(rd), opc};
    endfunction

    task automatic put(input logic [31:0] ins);
        imem[p_idx] = ins;
        p_idx++;
    endtask
    task automatic exp_st(input logic [31:0] addr, input logic [31:0] data);
        st_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask
    task automatic alu_case(input logic [31:0] ins, input logic [31:0] exp);
        put(ins);
        put(sw(5, 0, 8));
        exp_st(32'd8, exp);
    endtask

    task automatic begin_test();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = jal(0, 0);
        exp_q.delete();
        p_idx = 0;
    endtask
    task automatic run(input string name, input int cycles);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (cycles) @(negedge clk);
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    localparam logic [31:0] JMP_TRACE [0:18] = '{
        32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
        32'h30, 32'h24, 32'h28, 32'h2C, 32'h3C, 32'h40, 32'h48, 32'h4C, 32'h4C, 32'h4C};

    initial begin
        logic [31:0] fa, fb, fc, pc_auipc;
        logic [31:0] trace_exp [0:18];
        trace_exp = JMP_TRACE;

        // ALU: add/sub and a stored result per OP/OP-IMM variant
        begin_test();
        put(i_op(3'b000, 1, 0, 5));
        put(i_op(3'b000, 2, 0, -3));
        put(r_op(7'h00, 3'b000, 3, 1, 2));
        put(sw(3, 0, 0));                     exp_st(32'd0, 32'd2);
        put(r_op(7'h20, 3'b000, 4, 2, 1));
        put(sw(4, 0, 4));                     exp_st(32'd4, 32'hFFFF_FFF8);
        put(u_op(7'b0110111, 7, 32'h80000));
        put(i_op(3'b000, 7, 7, -1));
        alu_case(i_op(3'b000, 5, 7, 1),            32'h8000_0000);
        alu_case(r_op(7'h00, 3'b010, 5, 2, 1),     32'd1);
        alu_case(r_op(7'h00, 3'b011, 5, 2, 1),     32'd0);
        alu_case(r_op(7'h00, 3'b100, 5, 1, 2),     32'hFFFF_FFF8);
        alu_case(r_op(7'h00, 3'b110, 5, 1, 2),     32'hFFFF_FFFD);
        alu_case(r_op(7'h00, 3'b111, 5, 1, 2),     32'd5);
        alu_case(r_op(7'h00, 3'b001, 5, 1, 1),     32'hA0);
        alu_case(r_op(7'h00, 3'b101, 5, 2, 1),     32'h07FF_FFFF);
        alu_case(r_op(7'h20, 3'b101, 5, 2, 1),     32'hFFFF_FFFF);
        alu_case(i_op(3'b001, 5, 1, 31),           32'h8000_0000);
        alu_case(i_op(3'b101, 5, 2, 28),           32'hF);
        alu_case(i_op(3'b101, 5, 2, 32'h401),      32'hFFFF_FFFE);
        alu_case(i_op(3'b010, 5, 1, -1),           32'd0);
        alu_case(i_op(3'b011, 5, 1, -1),           32'd1);
        alu_case(i_op(3'b100, 5, 1, -1),           32'hFFFF_FFFA);
        alu_case(i_op(3'b110, 5, 1, 32'h30),       32'h35);
        alu_case(i_op(3'b111, 5, 2, 32'hF0),       32'hF0);
        put(i_op(3'b000, 0, 0, 7));
        put(sw(0, 0, 12));                    exp_st(32'd12, 32'd0);
        pc_auipc = 32'(p_idx * 4);
        put(u_op(7'b0010111, 6, 1));
        put(sw(6, 0, 16));                    exp_st(32'd16, pc_auipc + 32'h1000);
        run("alu", 200);

        // async reset from a running program, then release timing
        begin_test();
        #1;
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_dmem_write", 32'(dmem_write), 32'd0);
        chk("rst_dmem_read", 32'(dmem_read), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        put(i_op(3'b000, 0, 0, 0));
        put(i_op(3'b000, 0, 0, 0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("rel_pc_a", imem_addr, 32'd0);
        @(negedge clk);
        chk("rel_pc_b", imem_addr, 32'd0);
        @(negedge clk);
        chk("rel_pc_c", imem_addr, 32'd4);

        // load/store round trip and load latency
        begin_test();
        put(u_op(7'b0110111, 1, 32'h12345));
        put(i_op(3'b000, 1, 1, 32'h678));
        put(sw(1, 0, 8));                     exp_st(32'd8, 32'h1234_5678);
        put(lw(4, 0, 8));
        put(sw(4, 0, 12));                    exp_st(32'd12, 32'h1234_5678);
        run("ldst", 60);
        chk("ldst_lw_cycles", 32'(pc_cyc[3]), 32'd3);
        chk("ldst_sw_cycles", 32'(pc_cyc[2]), 32'd2);
        chk("ldst_word3", dmem[3], 32'h1234_5678);

        // branches: taken/not-taken for each compare flavour
        begin_test();
        put(i_op(3'b000, 1, 0, -1));          // 00
        put(i_op(3'b000, 2, 0, 1));           // 04
        put(i_op(3'b000, 3, 3, 1));           // 08
        put(sw(3, 0, 0));                     // 0C
        put(br(3'b000, 3, 2, -8));            // 10 beq back once
        put(br(3'b001, 0, 0, -8));            // 14 bne not taken
        put(br(3'b100, 1, 2, 8));             // 18 blt taken
        put(sw(1, 0, 16));                    // 1C skipped
        put(br(3'b110, 1, 2, 8));             // 20 bltu not taken
        put(sw(2, 0, 20));                    // 24
        put(br(3'b101, 1, 2, 8));             // 28 bge not taken
        put(br(3'b111, 1, 2, 8));             // 2C bgeu taken
        put(sw(1, 0, 24));                    // 30 skipped
        put(sw(1, 0, 28));                    // 34
        put(br(3'b001, 1, 2, 8));             // 38 bne taken
        put(sw(0, 0, 32));                    // 3C skipped
        exp_st(32'd0, 32'd1);
        exp_st(32'd0, 32'd2);
        exp_st(32'd20, 32'd1);
        exp_st(32'd28, 32'hFFFF_FFFF);
        run("br", 100);

        // jumps: link values, JALR low-bit clear, x0 writes discarded
        begin_test();
        for (int i = 0; i < 8; i++) put(i_op(3'b000, 0, 0, 0));
        put(jal(1, 16));                      // 20
        put(sw(1, 0, 0));                     // 24
        put(i_op(3'b000, 0, 0, 7));           // 28
        put(jal(0, 16));                      // 2C -> 3C
        put(jalr(0, 1, 0));                   // 30 -> 24
        put(sw(1, 0, 12));                    // 34 skipped
        put(sw(1, 0, 12));                    // 38 skipped
        put(sw(0, 0, 4));                     // 3C
        put(jalr(6, 0, 32'h49));              // 40 -> 48
        put(sw(1, 0, 12));                    // 44 skipped
        put(sw(6, 0, 8));                     // 48
        exp_st(32'd0, 32'h24);
        exp_st(32'd4, 32'd0);
        exp_st(32'd8, 32'h44);
        run("jmp", 60);
        chk("jmp_trace_len", 32'(fetch_q.size()), 32'd17);
        for (int i = 0; i < 17; i++)
            if (i < fetch_q.size()) chk($sformatf("jmp_trace%0d", i), fetch_q[i], trace_exp[i]);

        // Fibonacci through memory, must finish within 150 cycles
        begin_test();
        put(sw(0, 0, 0));
        put(i_op(3'b000, 1, 0, 1));
        put(sw(1, 0, 4));
        put(i_op(3'b000, 2, 0, 8));
        put(i_op(3'b000, 3, 0, 40));
        put(lw(4, 2, -8));
        put(lw(5, 2, -4));
        put(r_op(7'h00, 3'b000, 6, 4, 5));
        put(sw(6, 2, 0));
        put(i_op(3'b000, 2, 2, 4));
        put(br(3'b001, 2, 3, -20));
        fa = 0;
        fb = 1;
        exp_st(32'd0, fa);
        exp_st(32'd4, fb);
        for (int i = 2; i < 10; i++) begin
            fc = fa + fb;
            exp_st(32'(i * 4), fc);
            fa = fb;
            fb = fc;
        end
        run("fib", 150);
        fa = 0;
        fb = 1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("fib_word%0d", i), dmem[i], fa);
            fc = fa + fb;
            fa = fb;
            fb = fc;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
